// File: rtl/interrupt_controller_pkg.sv
// Shared processor constants for the interrupt controller: FSM encoding,
// default acknowledge timeout and wait-counter width.
package interrupt_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

    localparam int ACK_TIMEOUT_DEFAULT = 255;

    // Wide enough for the largest legal ACK_TIMEOUT (255).
    localparam int CNT_W = 8;

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Fixed-priority encoder: the lowest-numbered line that is both pending and
// enabled wins. Purely combinational.
module irq_priority_encoder #(
    parameter int NUM_IRQ = 4
) (
    input  logic [NUM_IRQ-1:0]         pending,
    input  logic [NUM_IRQ-1:0]         mask,
    output logic                       valid,
    output logic [$clog2(NUM_IRQ)-1:0] index
);

    localparam int ID_W = $clog2(NUM_IRQ);

    logic [NUM_IRQ-1:0] eligible;

    always_comb begin
        eligible = pending & mask;
        valid    = 1'b0;
        index    = '0;
        // Scan from the top down so the last hit, the lowest index, sticks.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                valid = 1'b1;
                index = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// Single-level, non-nesting interrupt controller: edge-latched requests,
// fixed priority dispatch, ack handshake with timeout, and reti completion.
module interrupt_controller
    import interrupt_controller_pkg::*;
#(
    parameter int NUM_IRQ     = 4,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_IRQ-1:0]         irq_in,
    input  logic [NUM_IRQ-1:0]         irq_mask,
    input  logic                       intr_ack,
    input  logic                       reti,
    output logic                       interrupt,
    output logic [$clog2(NUM_IRQ)-1:0] intr_id,
    output logic                       in_service,
    output logic [NUM_IRQ-1:0]         pending,
    output logic                       timeout_err
);

    localparam int ID_W = $clog2(NUM_IRQ);

    irq_state_e         state_q, state_d;
    logic [NUM_IRQ-1:0] irq_q, irq_d;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [ID_W-1:0]    intr_id_q, intr_id_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               interrupt_q, interrupt_d;
    logic               in_service_q, in_service_d;
    logic               timeout_err_q, timeout_err_d;

    logic               win_valid;
    logic [ID_W-1:0]    win_idx;
    logic [NUM_IRQ-1:0] edges;
    logic [NUM_IRQ-1:0] clear_mask;
    logic               ack_take;
    logic               expire;

    irq_priority_encoder #(
        .NUM_IRQ (NUM_IRQ)
    ) u_prio (
        .pending (pending_q),
        .mask    (irq_mask),
        .valid   (win_valid),
        .index   (win_idx)
    );

    // The wait counter holds the number of REQ cycles already spent, so the
    // request is withdrawn at the end of its ACK_TIMEOUT-th REQ cycle.
    always_comb begin
        edges    = irq_in & ~irq_q;
        ack_take = (state_q == ST_REQ) && intr_ack;
        expire   = (state_q == ST_REQ) && !intr_ack
                   && (wait_cnt_q == CNT_W'(ACK_TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            irq_q         <= '0;
            pending_q     <= '0;
            intr_id_q     <= '0;
            wait_cnt_q    <= '0;
            interrupt_q   <= 1'b0;
            in_service_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            irq_q         <= irq_d;
            pending_q     <= pending_d;
            intr_id_q     <= intr_id_d;
            wait_cnt_q    <= wait_cnt_d;
            interrupt_q   <= interrupt_d;
            in_service_q  <= in_service_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (win_valid) state_d = ST_REQ;
            end
            ST_REQ: begin
                if (ack_take)    state_d = ST_SERVICE;
                else if (expire) state_d = ST_IDLE;
            end
            ST_SERVICE: begin
                if (reti) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A fresh edge on the line being cleared wins, so the request is not lost.
    always_comb begin
        irq_d        = irq_in;
        interrupt_d  = (state_d == ST_REQ);
        in_service_d = (state_d == ST_SERVICE);

        intr_id_d = intr_id_q;
        if ((state_q == ST_IDLE) && win_valid) intr_id_d = win_idx;

        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_IDLE)     wait_cnt_d = '0;
        else if (state_q == ST_REQ) wait_cnt_d = wait_cnt_q + 1'b1;

        clear_mask = '0;
        if (ack_take || expire) clear_mask[intr_id_q] = 1'b1;
        pending_d = (pending_q & ~clear_mask) | edges;

        timeout_err_d = timeout_err_q | expire;
    end

    assign interrupt   = interrupt_q;
    assign intr_id     = intr_id_q;
    assign in_service  = in_service_q;
    assign pending     = pending_q;
    assign timeout_err = timeout_err_q;

endmodule
